// File: rtl/fib_pkg.sv
// Shared constants and encodings for the Fibonacci datapath and its recursion call stack.
package fib_pkg;

    localparam int FIB_WIDTH       = 8;
    localparam int FIB_STACK_DEPTH = 16;

    // Selects which datapath value the datapath drives onto the stack's din.
    typedef enum logic [1:0] {
        STK_SEL_FLAG   = 2'b00,
        STK_SEL_N      = 2'b01,
        STK_SEL_RESULT = 2'b10,
        STK_SEL_ZERO   = 2'b11
    } stk_sel_e;

    // Stack operation decoded from {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_e;

    function automatic int addr_width(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

endpackage

// File: rtl/call_stack_mem.sv
// Storage below the top-of-stack register: one synchronous write port, one asynchronous read port.
module call_stack_mem #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 15,
    parameter int AW      = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack.sv
// LIFO for Fibonacci recursion frames with a registered top-of-stack, status and sticky error flags.
// Optional high-water mark output enabled by defining CALL_STACK_HWM_EN.
module call_stack
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH,
    parameter int DEPTH = FIB_STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf,
`ifdef CALL_STACK_HWM_EN
    output logic [$clog2(DEPTH+1)-1:0] hwm,
`endif
    input  logic                       clr_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = addr_width(DEPTH - 1);

    logic [WIDTH-1:0] top_q, top_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             is_empty, is_full;
    logic             mem_we;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [WIDTH-1:0] mem_rdata;
    stack_op_e        op;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    // Entry below the top sits at count-2; the old top is spilled to count-1.
    assign wr_addr  = AW'(count_q - CW'(1));
    assign rd_addr  = AW'(count_q - CW'(2));
    assign op       = stack_op_e'({push, pop});

    call_stack_mem #(
        .WIDTH   (WIDTH),
        .ENTRIES (DEPTH - 1),
        .AW      (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (top_q),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        ovf_d   = ovf_q & ~clr_err;
        unf_d   = unf_q & ~clr_err;
        mem_we  = 1'b0;
        case (op)
            OP_PUSH: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we  = ~is_empty;
                    top_d   = din;
                    count_d = count_q + CW'(1);
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    unf_d = 1'b1;
                end else if (count_q == CW'(1)) begin
                    top_d   = '0;
                    count_d = '0;
                end else begin
                    top_d   = mem_rdata;
                    count_d = count_q - CW'(1);
                end
            end
            OP_REPLACE: begin
                // On an empty stack this degenerates to a push but still records the bad pop.
                top_d = din;
                if (is_empty) begin
                    count_d = CW'(1);
                    unf_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            top_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef CALL_STACK_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (clr_err) begin
            hwm_d = count_q;
        end else if (count_q > hwm_q) begin
            hwm_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

    assign dout  = top_q;
    assign count = count_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule
